l2_arbiter: RTL
===============

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 Parameter L1_BLOCK_SIZE, default 16, words per L1 block transfer.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 Port rqN_addr (N=0,1), input, ADDR_WIDTH, requester N address.
REQ-007 Port rqN_data_in, input, L1_BLOCK_SIZE x DATA_WIDTH, requester N write block.
REQ-008 Port rqN_read / rqN_write, input, 1 each, requester N request; held until rqN_ready.
REQ-009 Port rqN_data_out, output, L1_BLOCK_SIZE x DATA_WIDTH, read block returned to requester N.
REQ-010 Port rqN_ready, output, 1, one-cycle completion pulse to requester N.
REQ-011 Port l2_cache_addr, output, ADDR_WIDTH, address to shared L2.
REQ-012 Port l2_cache_data_in, output, L1_BLOCK_SIZE x DATA_WIDTH, write block to L2.
REQ-013 Port l2_cache_data_out, input, L1_BLOCK_SIZE x DATA_WIDTH, read block from L2.
REQ-014 Port l2_cache_read / l2_cache_write, output, 1 each, L2 request strobes.
REQ-015 Port l2_cache_ready, input, 1, L2 completion indication.
REQ-016 Port grant_id, output, 1, index of requester currently owning L2; 0 when idle.
REQ-017 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, RESP.
REQ-019 IDLE: if any rqN_read|rqN_write is high, select a winner, latch its addr, data_in and op (write wins if both read and write are high), set grant_id, go ISSUE; otherwise stay.
REQ-020 Only one requester requesting: it wins regardless of arbitration policy.
REQ-021 ISSUE: l2_cache_read/write SHALL equal latched op AND NOT l2_cache_ready (combinational gating), so the strobe drops in the same cycle L2 signals ready.
REQ-022 ISSUE: on l2_cache_ready=1, capture l2_cache_data_out into the winner's rqN_data_out register (reads only), go RESP; otherwise stay, with no timeout.
REQ-023 RESP: assert winner's rqN_ready for exactly one cycle, go IDLE; l2_cache_read/write SHALL be 0.
REQ-024 Minimum request-to-ready latency SHALL be L2 latency + 2 cycles (IDLE sample, RESP).
REQ-025 l2_cache_addr and l2_cache_data_in SHALL be driven from latched values, stable from ISSUE entry through RESP.
REQ-026 Input changes on the winner's request lines during ISSUE/RESP SHALL be ignored; the loser's request SHALL be held pending, never dropped.
REQ-027 rqN_data_out of the non-winner SHALL hold its previous value.
REQ-028 A write completion SHALL NOT modify rqN_data_out.

Reset
REQ-029 When rst_n=0 at a rising edge: state IDLE, rq0_ready=rq1_ready=0, rqN_data_out=0, l2_cache_addr=0, l2_cache_data_in=0, l2_cache_read=l2_cache_write=0, grant_id=0, busy=0, round-robin pointer=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it without any rqN_ready pulse; L2 is reset by the same rst_n.

Configuration
REQ-031 Macro L2_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the winner is the requester not served last (pointer toggles at each RESP), pointer starting at requester 0 after reset.
REQ-032 Macro L2_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins simultaneous requests; no pointer state exists.

Verification
REQ-033 rq0_read=1, addr 0x0000_0040, L2 ready after 6 cycles with block 0xA5 pattern -> one L2 read strobe, rq0_ready single pulse 8 cycles after request, rq0_data_out = pattern, rq1 outputs unchanged.
REQ-034 rq0_read and rq1_write asserted same cycle, two back-to-back rounds, round-robin build -> grants 0,1,0,1; fixed-priority build -> requester 0 served first each round, requester 1 served next without loss.
REQ-035 rq1_write, addr 0x0000_1000, data 0x1234_5678 per word -> l2_cache_write high until l2_cache_ready, l2_cache_data_in matches, rq1_data_out unchanged.
REQ-036 l2_cache_ready asserted in ISSUE -> l2_cache_read deasserted same cycle; no second L2 request issued before next IDLE sample.
REQ-037 rst_n=0 for one cycle while in ISSUE -> next cycle all outputs at reset values, no rqN_ready pulse, busy=0.
REQ-038 Requester 1 raises rq1_read while requester 0 in ISSUE -> request 1 served immediately after requester 0's RESP, grant_id=1.

Source files
------------

// File: rtl/l2_arbiter.sv
// Two-requester arbiter in front of a shared L2: one outstanding L2 transaction at a time.
// Latency: request-to-ready = L2 latency + 2 cycles (IDLE sample, then RESP pulse).
// Backpressure: requesters hold read/write until their ready pulse; the loser stays pending.
//
// Ports:
//   clk, rst_n                      - single clock, synchronous active-low reset
//   rqN_addr/data_in/read/write     - requester N request (N = 0, 1), held until rqN_ready
//   rqN_data_out, rqN_ready         - returned read block and one-cycle completion pulse
//   l2_cache_addr/data_in/read/write- request to the shared L2, driven from latched values
//   l2_cache_data_out, l2_cache_ready - L2 response
//   grant_id, busy                  - current owner (0 when idle), non-IDLE indication
//
// Build option: define L2_ARB_ROUND_ROBIN_EN for round-robin arbitration between
// simultaneous requests; otherwise requester 0 has fixed priority.

module l2_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int L1_BLOCK_SIZE = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic [ADDR_WIDTH-1:0]                 rq0_addr,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   rq0_data_in,
    input  logic                                  rq0_read,
    input  logic                                  rq0_write,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   rq0_data_out,
    output logic                                  rq0_ready,

    input  logic [ADDR_WIDTH-1:0]                 rq1_addr,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   rq1_data_in,
    input  logic                                  rq1_read,
    input  logic                                  rq1_write,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   rq1_data_out,
    output logic                                  rq1_ready,

    output logic [ADDR_WIDTH-1:0]                 l2_cache_addr,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   l2_cache_data_in,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   l2_cache_data_out,
    output logic                                  l2_cache_read,
    output logic                                  l2_cache_write,
    input  logic                                  l2_cache_ready,

    output logic                                  grant_id,
    output logic                                  busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0] state;
    logic       grant_q;     // owner of the current transaction, forced to 0 in IDLE
    logic       op_wr;       // latched operation: 1 = write, 0 = read

    logic       req0;
    logic       req1;
    logic       win;
    logic       win_wr;
    logic [ADDR_WIDTH-1:0]               win_addr;
    logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] win_data;

    assign req0 = rq0_read | rq0_write;
    assign req1 = rq1_read | rq1_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
    // rr_ptr names the requester preferred on a tie: the one not served last.
    logic rr_ptr;

    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = rr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (state == RESP) begin
            rr_ptr <= ~grant_q;
        end
    end
`else
    // Requester 0 wins any tie; requester 1 only wins when 0 is not asking.
    always_comb begin
        win = ~req0;
    end
`endif

    // Winner's request fields; a write strobe takes precedence over a read strobe.
    always_comb begin
        win_wr   = rq0_write;
        win_addr = rq0_addr;
        win_data = rq0_data_in;
        if (win) begin
            win_wr   = rq1_write;
            win_addr = rq1_addr;
            win_data = rq1_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            grant_q          <= 1'b0;
            op_wr            <= 1'b0;
            l2_cache_addr    <= '0;
            l2_cache_data_in <= '0;
            rq0_data_out     <= '0;
            rq1_data_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q          <= win;
                        op_wr            <= win_wr;
                        l2_cache_addr    <= win_addr;
                        l2_cache_data_in <= win_data;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (l2_cache_ready) begin
                        // Only reads return data; a write leaves both blocks untouched.
                        if (!op_wr) begin
                            if (grant_q) begin
                                rq1_data_out <= l2_cache_data_out;
                            end else begin
                                rq0_data_out <= l2_cache_data_out;
                            end
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    grant_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    grant_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by l2_cache_ready so they drop in the same cycle L2 completes,
    // which keeps L2 from seeing a second request before the next IDLE sample.
    assign l2_cache_read  = (state == ISSUE) && !op_wr && !l2_cache_ready;
    assign l2_cache_write = (state == ISSUE) &&  op_wr && !l2_cache_ready;

    assign rq0_ready = (state == RESP) && !grant_q;
    assign rq1_ready = (state == RESP) &&  grant_q;

    assign grant_id  = grant_q;
    assign busy      = (state != IDLE);

endmodule
